multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Control FSM for a multicycle MIPS datapath: one shared memory, one ALU, IR/A/B/ALUOut registers.
//  Sequences lw, sw, R-type (add/sub/and/or/slt), beq, addi and j through fetch/decode/execute/memory/writeback steps.
//  Drives every datapath mux select and write enable each cycle.
//  Inserts memory wait states via mem_ready.
// PARAMETERS
//  MEM_WAIT_EN  1  1: honour mem_ready; 0: mem_ready is ignored and treated as 1
// PORTS
//  clk        in   1  single clock; all state updates on the rising edge
//  reset      in   1  synchronous, active-high
//  op         in   6  IR[31:26]
//  funct      in   6  IR[5:0]
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  memory access completes this cycle
//  memtoreg   out  1  regfile write data: 1 = data reg, 0 = ALUOut
//  regdst     out  1  write register: 1 = rd, 0 = rt
//  iord       out  1  memory address: 1 = ALUOut, 0 = PC
//  alusrca    out  1  ALU A: 1 = reg A, 0 = PC
//  alusrcb    out  2  ALU B: 00 = reg B, 01 = 4, 10 = signext imm, 11 = signext imm<<2
//  pcsrc      out  2  PC next: 00 = ALU result, 01 = ALUOut, 10 = jump target
//  irwrite    out  1  IR load enable
//  memwrite   out  1  memory write enable
//  regwrite   out  1  register file write enable
//  pcen       out  1  PC load enable = pcwrite | (branch & zero)
//  alucontrol out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  state      out  4  current state code (debug/verification)
// BEHAVIOUR
//  - Moore FSM; outputs decode from the state register.
//  - Exception: in FETCH/MEMRD/MEMWR, enables qualify with rdy = mem_ready | ~MEM_WAIT_EN.
//  - Unlisted outputs are 0. alucontrol defaults to 010.
//  - Reset: state <= FETCH (0) on the edge reset is sampled high.
//  - While reset is high, irwrite/memwrite/regwrite/pcen are forced 0 regardless of state.
//  - Reset mid-instruction aborts it; no partial writes occur after the reset edge.
//  - State table, code: outputs -> next
//    FETCH 0:   iord=0 alusrca=0 alusrcb=01 add, irwrite=rdy, pcwrite=rdy -> DECODE if rdy, else hold
//    DECODE 1:  alusrca=0 alusrcb=11 add (branch target into ALUOut)
//               next by op: lw 100011 / sw 101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX;
//               001000 -> ADDIEX; 000010 -> JEX; any other op -> FETCH (no side effects)
//    MEMADR 2:  alusrca=1 alusrcb=10 add -> MEMRD if op=lw, MEMWR if op=sw
//    MEMRD 3:   iord=1 -> MEMWB if rdy, else hold
//    MEMWB 4:   regdst=0 memtoreg=1 regwrite=1 -> FETCH
//    MEMWR 5:   iord=1, memwrite held 1 until rdy -> FETCH on rdy
//    RTYPEEX 6: alusrca=1 alusrcb=00, alucontrol from funct
//               funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
//               -> RTYPEWB; unknown funct -> FETCH (no writeback)
//    RTYPEWB 7: regdst=1 memtoreg=0 regwrite=1, alucontrol still from funct -> FETCH
//    BEQEX 8:   alusrca=1 alusrcb=00 sub, branch=1 pcsrc=01 -> FETCH
//    ADDIEX 9:  alusrca=1 alusrcb=10 add -> ADDIWB
//    JEX 10:    pcsrc=10 pcwrite=1 -> FETCH
//    ADDIWB 11: regdst=0 memtoreg=0 regwrite=1 -> FETCH
//    Codes 12-15: all enables 0 -> FETCH
//  - op/funct come from IR; they are stable from DECODE onward because irwrite=0 outside FETCH.
//  - CPI with no wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
//  - Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
// TESTING
//  - lw, mem_ready=1: state 0,1,2,3,4,0; cycle 5 regwrite=1 memtoreg=1 regdst=0; irwrite=pcen=1 only in cycle 1.
//  - beq (op 000100): zero=1 -> state 8 pcen=1 pcsrc=01 alucontrol=110; zero=0 -> pcen=0.
//  - R-type funct 100010: RTYPEEX alucontrol=110; RTYPEWB regdst=1 regwrite=1; unknown funct 000001 -> 6 -> 0, regwrite never 1.
//  - mem_ready=0 three cycles in FETCH: state stays 0, irwrite=pcen=0; then 1 -> irwrite=pcen=1 and next state=1.
//  - With MEM_WAIT_EN=0, the same stimulus advances every cycle.
//  - sw with mem_ready low two cycles in MEMWR: memwrite=1 for 3 cycles, then FETCH.
//  - Reset asserted in MEMWR: memwrite=0 immediately; state=0 after the edge.
//  - Illegal op 111111: state 0 -> 1 -> 0; memwrite/regwrite stay 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle MIPS datapath with shared memory and wait-state support.
//
// state   | code | meaning
// --------+------+-----------------------------------------------------------
// FETCH   |  0   | read instruction at PC, PC <= PC+4; holds until memory ready
// DECODE  |  1   | read regs, branch target into ALUOut, dispatch on op
// MEMADR  |  2   | effective address A + signext(imm)
// MEMRD   |  3   | load data read at ALUOut; holds until memory ready
// MEMWB   |  4   | load data into rt
// MEMWR   |  5   | store B at ALUOut; write enable held until memory ready
// RTYPEEX |  6   | A op B per funct; unknown funct aborts to FETCH
// RTYPEWB |  7   | ALUOut into rd
// BEQEX   |  8   | A - B, take branch target if zero
// ADDIEX  |  9   | A + signext(imm)
// JEX     | 10   | PC <= jump target
// ADDIWB  | 11   | ALUOut into rt
// 12..15  |  -   | unreachable; recover to FETCH with no side effects
module multicycle_controller #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memtoreg,
  output logic       regdst,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_JEX     = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q, state_d;

  logic rdy;
  logic funct_ok;
  logic [2:0] funct_alu;
  logic pcwrite, branch;
  logic irwrite_raw, memwrite_raw, regwrite_raw;

  // With wait states disabled every memory access completes in one cycle.
  assign rdy = mem_ready | (MEM_WAIT_EN == 1'b0);

  // Decode the R-type function field into an ALU operation.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // State register; reset returns to FETCH.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d      = S_FETCH;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    iord         = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    alucontrol   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alusrcb     = 2'b01;
        irwrite_raw = rdy;
        pcwrite     = rdy;
        state_d     = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_MEMWR: begin
        // Write strobe stays up for the whole access, including the ready cycle.
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        state_d      = rdy ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
        state_d    = funct_ok ? S_RTYPEWB : S_FETCH;
      end
      S_RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
        alucontrol   = funct_alu;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        branch     = 1'b1;
        pcsrc      = 2'b01;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset suppresses every architectural write so an aborted instruction leaves no trace.
  assign irwrite  = irwrite_raw  & ~reset;
  assign memwrite = memwrite_raw & ~reset;
  assign regwrite = regwrite_raw & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;
  assign state    = state_q;

endmodule
